// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t     : converter FSM states (ST_IDLE, ST_SHIFT)
//   ADJ_THRESH  : digit value at or above which the double-dabble correction applies
//   ADJ_ADD     : correction added to a digit before each shift
//   max_val()   : largest value representable in a given number of BCD digits
//   cnt_width() : shift-counter width for a given binary input width
package bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // 10^digits - 1
  function automatic int unsigned max_val(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// The 4-bit sum wraps; no carry leaves the digit.
// Ports:
//   digit_in  in  4  BCD digit before correction
//   digit_out out 4  corrected digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADJ_THRESH) begin
      digit_out = digit_in + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: binary input -> packed BCD digits,
// one shift per clock. Output feeds a multi-digit 7-segment display driver
// ([4*DIGITS-1 -: 4] = most significant digit .. [3:0] = units).
//
// Parameters:
//   BIN_W   width of the binary input
//   DIGITS  number of BCD digits produced (MAX_VAL = 10^DIGITS - 1)
// Ports:
//   clk    in   1          system clock, rising edge
//   rst    in   1          synchronous active-high reset
//   start  in   1          conversion request, sampled only while idle
//   bin    in   BIN_W      binary value, captured on an accepted start
//   busy   out  1          conversion in progress
//   valid  out  1          one-cycle pulse when bcd/ovf are updated
//   bcd    out  4*DIGITS   packed BCD result, held until next valid
//   ovf    out  1          captured bin exceeded MAX_VAL, held with bcd
// Build option:
//   BCD_CLAMP_EN  when defined, an out-of-range input converts as MAX_VAL
//                 (all-9 digits); otherwise it converts as-is, so bcd
//                 shows bin modulo 10^DIGITS. ovf is set either way.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned MAX_VAL = max_val(DIGITS);
  localparam int unsigned CNT_W   = cnt_width(BIN_W);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_work_q, bin_work_d;
  logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic               over_max;
  logic [BIN_W-1:0]   load_val;
  logic [BCD_W-1:0]   adj_bcd;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic               unused_adj_msb;

  assign over_max = (32'(bin) > MAX_VAL);

  always_comb begin
`ifdef BCD_CLAMP_EN
    load_val = over_max ? BIN_W'(MAX_VAL) : bin;
`else
    load_val = bin;
`endif
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_work_q[4*g +: 4]),
      .digit_out (adj_bcd[4*g +: 4])
    );
  end

  // Shift {adjusted digits, binary} left by one; the bit leaving the top
  // digit is dropped, so oversized inputs wrap modulo 10^DIGITS.
  assign bcd_shift      = {adj_bcd[BCD_W-2:0], bin_work_q[BIN_W-1]};
  assign bin_shift      = {bin_work_q[BIN_W-2:0], 1'b0};
  assign unused_adj_msb = adj_bcd[BCD_W-1];

  always_comb begin
    state_d    = state_q;
    bin_work_d = bin_work_q;
    bcd_work_d = bcd_work_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          bin_work_d = load_val;
          bcd_work_d = '0;
          ovf_pend_d = over_max;
          cnt_d      = CNT_W'(BIN_W - 1);
        end
      end
      ST_SHIFT: begin
        bin_work_d = bin_shift;
        bcd_work_d = bcd_shift;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Final shift: publish the result directly from the shift path.
          state_d = ST_IDLE;
          cnt_d   = '0;
          bcd_d   = bcd_shift;
          ovf_d   = ovf_pend_q;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_work_q <= '0;
      bcd_work_q <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_work_q <= bin_work_d;
      bcd_work_q <= bcd_work_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign valid = valid_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;

endmodule
